// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter clocked directly from hwclk.
//
// Frame format: one start bit (low), then DATA_W data bits LSB first, then an
// optional parity bit, then STOP_BITS stop bits (high). The bit period is
// CLKS_PER_BIT = CLK_FREQ / BAUD cycles of hwclk. No derived baud clock is used.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   - PARITY state compiled in; every frame carries a parity bit
//               (even when PARITY_ODD = 0, odd when PARITY_ODD = 1).
//   undefined - DATA goes straight to STOP; PARITY_ODD is ignored.
//
// Ports:
//   hwclk      in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   tx_data    in   word to send, sampled only on handshake
//   tx_valid   in   source has a word
//   tx_ready   out  high only in IDLE; accept on tx_valid && tx_ready
//   ftdi_tx    out  serial line, idle high, driven from a flop
//   busy       out  high while a frame is in flight
//   frame_done out  one-cycle pulse in the last cycle of the final stop bit
module uart_tx_param #(
  parameter int unsigned CLK_FREQ   = 12000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              hwclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              ftdi_tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned IdxW       = $clog2(DATA_W);
  localparam logic [CntW-1:0] BitLast = CntW'(ClksPerBit - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

  if (ClksPerBit < 2 || DATA_W < 5 || DATA_W > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD > 1) begin : g_param_check
    $error("uart_tx_param: illegal parameter set");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_timer, w_timer_d;
  logic [IdxW-1:0]   r_bit_idx, w_bit_idx_d;
  logic              r_stop_idx, w_stop_idx_d;
  logic [DATA_W-1:0] r_shift, w_shift_d;
  logic              r_tx, w_tx_d;
  logic              w_bit_end;
  logic              w_stop_last;
`ifdef UART_TX_PARITY_EN
  logic              r_par, w_par_d;
`endif

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_timer    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_timer    <= w_timer_d;
      r_bit_idx  <= w_bit_idx_d;
      r_stop_idx <= w_stop_idx_d;
      r_shift    <= w_shift_d;
      r_tx       <= w_tx_d;
`ifdef UART_TX_PARITY_EN
      r_par      <= w_par_d;
`endif
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_timer_d    = r_timer;
    w_bit_idx_d  = r_bit_idx;
    w_stop_idx_d = r_stop_idx;
    w_shift_d    = r_shift;
    w_tx_d       = 1'b1;
`ifdef UART_TX_PARITY_EN
    w_par_d      = r_par;
`endif
    w_bit_end    = (r_timer == BitLast);
    w_stop_last  = (r_stop_idx == 1'(STOP_BITS - 1));

    // Timer wraps exactly at each bit boundary, so every bit is ClksPerBit long.
    if (r_state != StIdle) begin
      w_timer_d = w_bit_end ? '0 : r_timer + 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        w_timer_d = '0;
        if (tx_valid) begin
          w_state_d    = StStart;
          w_shift_d    = tx_data;
          w_bit_idx_d  = '0;
          w_stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_par_d      = (^tx_data) ^ 1'(PARITY_ODD);
`endif
        end
      end
      StStart: begin
        if (w_bit_end) w_state_d = StData;
      end
      StData: begin
        if (w_bit_end) begin
          if (r_bit_idx == IdxLast) begin
`ifdef UART_TX_PARITY_EN
            w_state_d = StParity;
`else
            w_state_d = StStop;
`endif
          end else begin
            w_bit_idx_d = r_bit_idx + 1'b1;
            w_shift_d   = {1'b0, r_shift[DATA_W-1:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (w_bit_end) w_state_d = StStop;
      end
`endif
      StStop: begin
        if (w_bit_end) begin
          if (w_stop_last) w_state_d = StIdle;
          else             w_stop_idx_d = r_stop_idx + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Line level is registered from the next state so ftdi_tx is glitch-free.
    case (w_state_d)
      StStart:  w_tx_d = 1'b0;
      StData:   w_tx_d = w_shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: w_tx_d = w_par_d;
`endif
      default:  w_tx_d = 1'b1;
    endcase
  end

  assign tx_ready   = (r_state == StIdle);
  assign busy       = (r_state != StIdle);
  assign frame_done = (r_state == StStop) && w_bit_end && w_stop_last;
  assign ftdi_tx    = r_tx;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: default 9600-baud instance, a small
// 7-bit / 2-stop / 4-clock instance and, with UART_TX_PARITY_EN, two parity
// instances (even and odd).
module tb_uart_tx_param;

  localparam int CDef = 1250;
`ifdef UART_TX_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif
  localparam int FDef = (10 + int'(ParEn)) * CDef;
  localparam int CSm  = 4;
  localparam int FSm  = (1 + 7 + int'(ParEn) + 2) * CSm;

  logic clk, rst;
  int   n_tests, n_fail;

  logic [7:0] d_data;
  logic       d_valid, d_ready, d_tx, d_busy, d_done;
  logic [6:0] s_data;
  logic       s_valid, s_ready, s_tx, s_busy, s_done;

  uart_tx_param #(
    .CLK_FREQ(12000000), .BAUD(9600), .DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) u_def (
    .hwclk(clk), .rst(rst), .tx_data(d_data), .tx_valid(d_valid), .tx_ready(d_ready),
    .ftdi_tx(d_tx), .busy(d_busy), .frame_done(d_done)
  );

  uart_tx_param #(
    .CLK_FREQ(4), .BAUD(1), .DATA_W(7), .STOP_BITS(2), .PARITY_ODD(0)
  ) u_small (
    .hwclk(clk), .rst(rst), .tx_data(s_data), .tx_valid(s_valid), .tx_ready(s_ready),
    .ftdi_tx(s_tx), .busy(s_busy), .frame_done(s_done)
  );

`ifdef UART_TX_PARITY_EN
  logic [7:0] p_data;
  logic       p_valid;
  logic       pe_ready, pe_tx, pe_busy, pe_done;
  logic       po_ready, po_tx, po_busy, po_done;

  uart_tx_param #(
    .CLK_FREQ(4), .BAUD(1), .DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) u_par_even (
    .hwclk(clk), .rst(rst), .tx_data(p_data), .tx_valid(p_valid), .tx_ready(pe_ready),
    .ftdi_tx(pe_tx), .busy(pe_busy), .frame_done(pe_done)
  );

  uart_tx_param #(
    .CLK_FREQ(4), .BAUD(1), .DATA_W(8), .STOP_BITS(1), .PARITY_ODD(1)
  ) u_par_odd (
    .hwclk(clk), .rst(rst), .tx_data(p_data), .tx_valid(p_valid), .tx_ready(po_ready),
    .ftdi_tx(po_tx), .busy(po_busy), .frame_done(po_done)
  );
`endif

  always #5 clk = ~clk;

  // Expected line level for frame bit b (0 = start) of word w.
  function automatic logic exp_bit(input logic [8:0] w, input int b, input int dw,
                                   input bit odd);
    logic p;
    if (b == 0) return 1'b0;
    if (b <= dw) return w[b-1];
    if (ParEn && b == dw + 1) begin
      p = odd;
      for (int i = 0; i < dw; i++) p ^= w[i];
      return p;
    end
    return 1'b1;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({d_tx, d_ready, d_busy, d_done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_def: got %b want 1100", {d_tx, d_ready, d_busy, d_done});
    end
    n_tests++;
    if ({s_tx, s_ready, s_busy, s_done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_small: got %b want 1100", {s_tx, s_ready, s_busy, s_done});
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int low_cnt, busy_cnt, done_cnt;
    low_cnt = 0; busy_cnt = 0; done_cnt = 0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      if (d_tx !== 1'b1 || s_tx !== 1'b1) low_cnt++;
      if (d_busy !== 1'b0 || s_busy !== 1'b0) busy_cnt++;
      if (d_done !== 1'b0 || s_done !== 1'b0) done_cnt++;
    end
    n_tests++;
    if (low_cnt != 0) begin
      n_fail++; $display("FAIL idle_line: %0d non-high cycles, want 0", low_cnt);
    end
    n_tests++;
    if (busy_cnt != 0) begin
      n_fail++; $display("FAIL idle_busy: %0d busy cycles, want 0", busy_cnt);
    end
    n_tests++;
    if (done_cnt != 0) begin
      n_fail++; $display("FAIL idle_done: %0d done cycles, want 0", done_cnt);
    end
  endtask

  task automatic test_default_frame();
    logic e;
    @(negedge clk);
    n_tests++;
    if (d_ready !== 1'b1) begin
      n_fail++; $display("FAIL a5_ready_pre: got %b want 1", d_ready);
    end
    d_data = 8'hA5; d_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= FDef + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        d_valid = 1'b0; d_data = 8'h5A;
        n_tests++;
        if ({d_ready, d_busy} !== 2'b01) begin
          n_fail++; $display("FAIL a5_accept: ready/busy %b want 01", {d_ready, d_busy});
        end
      end
      if (n <= FDef && ((n - 1) % CDef == 0 || n % CDef == 0)) begin
        e = exp_bit({1'b0, 8'hA5}, (n - 1) / CDef, 8, 1'b0);
        n_tests++;
        if (d_tx !== e) begin
          n_fail++; $display("FAIL a5_line cyc%0d: got %b want %b", n, d_tx, e);
        end
      end
      if (n >= FDef - 1) begin
        n_tests++;
        if (d_done !== (n == FDef)) begin
          n_fail++; $display("FAIL a5_done cyc%0d: got %b want %b", n, d_done, n == FDef);
        end
      end
      if (n == FDef + 1) begin
        n_tests++;
        if ({d_tx, d_ready, d_busy} !== 3'b110) begin
          n_fail++; $display("FAIL a5_end: got %b want 110", {d_tx, d_ready, d_busy});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    int   m;
    @(negedge clk);
    d_data = 8'h00; d_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 2 * FDef + 2; n++) begin
      @(negedge clk);
      if (n == 1) d_data = 8'hFF;
      if (n == FDef + 3) begin d_valid = 1'b0; d_data = 8'h00; end
      if (n <= FDef) begin
        if ((n - 1) % CDef == 0 || n % CDef == 0) begin
          e = exp_bit(9'h000, (n - 1) / CDef, 8, 1'b0);
          n_tests++;
          if (d_tx !== e) begin
            n_fail++; $display("FAIL b2b_w0 cyc%0d: got %b want %b", n, d_tx, e);
          end
        end
      end else if (n == FDef + 1) begin
        n_tests++;
        if ({d_tx, d_ready} !== 2'b11) begin
          n_fail++; $display("FAIL b2b_gap: tx/ready %b want 11", {d_tx, d_ready});
        end
      end else if (n <= 2 * FDef + 1) begin
        m = n - FDef - 1;
        if ((m - 1) % CDef == 0 || m % CDef == 0) begin
          e = exp_bit(9'h0FF, (m - 1) / CDef, 8, 1'b0);
          n_tests++;
          if (d_tx !== e) begin
            n_fail++; $display("FAIL b2b_w1 cyc%0d: got %b want %b", n, d_tx, e);
          end
        end
        if (m == FDef) begin
          n_tests++;
          if (d_done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_done2: got %b want 1", d_done);
          end
        end
      end else begin
        n_tests++;
        if ({d_tx, d_ready, d_busy} !== 3'b110) begin
          n_fail++; $display("FAIL b2b_end: got %b want 110", {d_tx, d_ready, d_busy});
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic e;
    @(negedge clk);
    d_data = 8'h3C; d_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 5000; n++) begin
      @(negedge clk);
      if (n == 1) d_valid = 1'b0;
    end
    n_tests++;
    if (d_busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: busy %b want 1", d_busy);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({d_tx, d_ready, d_busy, d_done} !== 4'b1100) begin
      n_fail++; $display("FAIL rstmid_async: got %b want 1100", {d_tx, d_ready, d_busy, d_done});
    end
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if ({d_tx, d_ready, d_busy} !== 3'b110) begin
      n_fail++; $display("FAIL rstmid_idle: got %b want 110", {d_tx, d_ready, d_busy});
    end
    d_data = 8'hC3; d_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= FDef + 1; n++) begin
      @(negedge clk);
      if (n == 1) d_valid = 1'b0;
      if (n <= FDef && ((n - 1) % CDef == 0 || n % CDef == 0)) begin
        e = exp_bit({1'b0, 8'hC3}, (n - 1) / CDef, 8, 1'b0);
        n_tests++;
        if (d_tx !== e) begin
          n_fail++; $display("FAIL rstmid_line cyc%0d: got %b want %b", n, d_tx, e);
        end
      end
      if (n == FDef) begin
        n_tests++;
        if (d_done !== 1'b1) begin
          n_fail++; $display("FAIL rstmid_done: got %b want 1", d_done);
        end
      end
      if (n == FDef + 1) begin
        n_tests++;
        if (d_ready !== 1'b1) begin
          n_fail++; $display("FAIL rstmid_ready: got %b want 1", d_ready);
        end
      end
    end
  endtask

  task automatic test_small_frame();
    logic e;
    @(negedge clk);
    s_data = 7'h55; s_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= FSm + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin s_valid = 1'b0; s_data = 7'h2A; end
      if (n <= FSm) begin
        e = exp_bit({2'b00, 7'h55}, (n - 1) / CSm, 7, 1'b0);
        n_tests++;
        if (s_tx !== e) begin
          n_fail++; $display("FAIL small_line cyc%0d: got %b want %b", n, s_tx, e);
        end
      end
      n_tests++;
      if (s_done !== (n == FSm)) begin
        n_fail++; $display("FAIL small_done cyc%0d: got %b want %b", n, s_done, n == FSm);
      end
    end
    n_tests++;
    if ({s_tx, s_ready, s_busy} !== 3'b110) begin
      n_fail++; $display("FAIL small_end: got %b want 110", {s_tx, s_ready, s_busy});
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    @(negedge clk);
    p_data = 8'h07; p_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 1) p_valid = 1'b0;
      // Parity bit is frame bit 9 at 4 clocks/bit: cycles 37..40.
      if (n == 38) begin
        n_tests++;
        if (pe_tx !== 1'b1) begin
          n_fail++; $display("FAIL par_even: got %b want 1", pe_tx);
        end
        n_tests++;
        if (po_tx !== 1'b0) begin
          n_fail++; $display("FAIL par_odd: got %b want 0", po_tx);
        end
      end
      if (n >= 43) begin
        n_tests++;
        if ({pe_done, po_done} !== {2{n == 44}}) begin
          n_fail++;
          $display("FAIL par_done cyc%0d: got %b want %b", n, {pe_done, po_done}, {2{n == 44}});
        end
      end
    end
    n_tests++;
    if ({pe_ready, pe_busy, po_ready, po_busy} !== 4'b1010) begin
      n_fail++;
      $display("FAIL par_end: got %b want 1010", {pe_ready, pe_busy, po_ready, po_busy});
    end
  endtask
`endif

  initial begin
    clk = 1'b0; rst = 1'b1;
    d_data = '0; d_valid = 1'b0;
    s_data = '0; s_valid = 1'b0;
`ifdef UART_TX_PARITY_EN
    p_data = '0; p_valid = 1'b0;
`endif
    n_tests = 0; n_fail = 0;
    test_reset();
    test_idle();
    test_default_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_small_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
